// File: rtl/core_ifetch.sv
// Single-outstanding instruction fetch: requests the PC word, buffers the response
// and hands it to decode on valid/ready; a flush discards anything in flight or held.
module core_ifetch #(
  parameter int WORD_ADDR_WIDTH = 30
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [WORD_ADDR_WIDTH-1:0] pc_waddr_i,
  input  logic                       flush_i,
  output logic                       pc_incr_o,
  output logic                       imem_req_o,
  output logic [WORD_ADDR_WIDTH-1:0] imem_waddr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [31:0]                imem_rdata_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [31:0]                instr_o,
  output logic [WORD_ADDR_WIDTH-1:0] instr_waddr_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]                 state_q;
  logic [WORD_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                instr_q;
  logic                       discard_q;

  // Request address tracks the PC live, so a redirect without grant re-targets it.
  assign imem_req_o    = (state_q == REQ);
  assign imem_waddr_o  = pc_waddr_i;
  assign instr_valid_o = (state_q == HOLD);
  assign instr_o       = instr_q;
  assign instr_waddr_o = addr_q;
  assign pc_incr_o     = instr_valid_o & instr_ready_i & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      instr_q   <= '0;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (imem_gnt_i) begin
            addr_q    <= pc_waddr_i;
            discard_q <= flush_i;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (discard_q | flush_i) begin
              discard_q <= 1'b0;
              state_q   <= REQ;
            end else begin
              instr_q <= imem_rdata_i;
              state_q <= HOLD;
            end
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready_i | flush_i) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a bus protocol violation.
  rvalid_only_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (state_q == WAIT));
`endif

endmodule
